// File: rtl/tcp_rx_mix_sched_if.sv
// Queue-side and output-side handshake bundle of the TCP RX cell-mix scheduler.
// The scheduler is the slave; the queue bank and the output mux side form the master.
interface tcp_rx_mix_sched_if #(
    parameter int QUE_NUM = 8
);
    localparam int QW = $clog2(QUE_NUM);

    logic [QUE_NUM-1:0] que_nempty;
    logic               out_rdy;
    logic [QUE_NUM-1:0] que_rd;
    logic [QW-1:0]      que_sel;
    logic               out_vld;
    logic               out_sop;
    logic               out_eop;

    modport master (
        output que_nempty, out_rdy,
        input  que_rd, que_sel, out_vld, out_sop, out_eop
    );

    modport slave (
        input  que_nempty, out_rdy,
        output que_rd, que_sel, out_vld, out_sop, out_eop
    );
endinterface

// File: rtl/tcp_rx_mix_sched.sv
// Packet-atomic round-robin scheduler: grants one queue, pops PDSZ cells, then
// optionally idles long enough to keep packet starts CELL_GAP cycles apart.
module tcp_rx_mix_sched #(
    parameter int QUE_NUM  = 8,
    parameter int PDSZ     = 4,
    parameter int CELL_GAP = 6,
    parameter int DBG_WID  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_limit_rate_en,
    tcp_rx_mix_sched_if.slave   bus,
    output logic                busy,
    output logic [DBG_WID-1:0]  dbg_sig
);
    localparam int QW       = $clog2(QUE_NUM);
    localparam int CW       = $clog2(PDSZ + 1);
    localparam int GW       = $clog2(CELL_GAP + 1);
    localparam bit GAP_EN   = (CELL_GAP > PDSZ + 1);
    localparam int GAP_LOAD = GAP_EN ? (CELL_GAP - PDSZ - 2) : 0;
    localparam int DBG_USED = 2 + QW + CW + GW + 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [QW-1:0]  sel_q;
    logic [QW-1:0]  rr_ptr;
    logic [CW-1:0]  cell_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [15:0]    pkt_cnt;

    logic           grant_vld;
    logic [QW-1:0]  grant_idx;
    logic [QW-1:0]  scan_idx;
    logic           take_grant;
    logic           rd_fire;
    logic           last_rd;

    logic           vld_p1;
    logic           sop_p1;
    logic           eop_p1;

    // Search starts just after the last granted queue, so it has lowest priority next.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 1; i <= QUE_NUM; i++) begin
            scan_idx = QW'((int'(rr_ptr) + i) % QUE_NUM);
            if (!grant_vld && bus.que_nempty[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_grant = 1'b0;
        rd_fire    = 1'b0;
        last_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    take_grant = 1'b1;
                    state_nxt  = XFER;
                end
            end
            XFER: begin
                if (bus.out_rdy) begin
                    rd_fire = 1'b1;
                    if (cell_cnt == CW'(PDSZ - 1)) begin
                        last_rd   = 1'b1;
                        state_nxt = (GAP_EN && cfg_limit_rate_en) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            rr_ptr   <= QW'(QUE_NUM - 1);
            cell_cnt <= '0;
            gap_cnt  <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (take_grant) begin
                sel_q    <= grant_idx;
                rr_ptr   <= grant_idx;
                cell_cnt <= '0;
            end else if (rd_fire) begin
                cell_cnt <= cell_cnt + 1'b1;
            end
            if (last_rd) pkt_cnt <= pkt_cnt + 1'b1;
            if (last_rd && state_nxt == GAP) gap_cnt <= GW'(GAP_LOAD);
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // stage p1: framing aligned with the mux output one cycle after the pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_fire;
            sop_p1 <= rd_fire && (cell_cnt == '0);
            eop_p1 <= last_rd;
        end
    end

    assign bus.que_rd  = rd_fire ? ({{(QUE_NUM-1){1'b0}}, 1'b1} << sel_q) : '0;
    assign bus.que_sel = sel_q;
    assign bus.out_vld = vld_p1;
    assign bus.out_sop = sop_p1;
    assign bus.out_eop = eop_p1;
    assign busy        = (state != IDLE);

    logic [DBG_USED-1:0] dbg_raw;
    assign dbg_raw = {state, rr_ptr, cell_cnt, gap_cnt, pkt_cnt};
    assign dbg_sig = DBG_WID'(dbg_raw);
endmodule

// File: tb/tb_tcp_rx_mix_sched.sv
// Directed bench for tcp_rx_mix_sched: framing, RR order, stalls, rate gap, reset, random invariants.
module tb_tcp_rx_mix_sched;
    localparam int QUE_NUM  = 8;
    localparam int PDSZ     = 4;
    localparam int CELL_GAP = 6;
    localparam int DBG_WID  = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_limit_rate_en;
    logic               busy;
    logic [DBG_WID-1:0] dbg_sig;

    int n_checks = 0;
    int n_fail   = 0;

    tcp_rx_mix_sched_if #(.QUE_NUM(QUE_NUM)) bus ();

    tcp_rx_mix_sched #(
        .QUE_NUM(QUE_NUM), .PDSZ(PDSZ), .CELL_GAP(CELL_GAP), .DBG_WID(DBG_WID)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_limit_rate_en(cfg_limit_rate_en),
        .bus              (bus),
        .busy             (busy),
        .dbg_sig          (dbg_sig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs after the falling edge, then let combinational outputs settle.
    task automatic step(input logic [7:0] ne, input logic rdy);
        @(negedge clk);
        bus.que_nempty = ne;
        bus.out_rdy    = rdy;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            step(8'h00, 1'b1);
            if (!busy) break;
        end
        chk("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] t1_vld  = 8'b10111100;
    logic [7:0] t1_sop  = 8'b10000100;
    logic [7:0] t1_eop  = 8'b00100000;
    logic [7:0] t1_busy = 8'b11011110;

    logic [7:0] t3_ne [9] = '{8'h04, 8'h04, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [8:0] t3_rdy  = 9'b111000111;
    logic [8:0] t3_rdm  = 9'b011000110;
    logic [8:0] t3_vld  = 9'b110001100;
    logic [8:0] t3_sop  = 9'b000000100;
    logic [8:0] t3_eop  = 9'b100000000;

    int         t2_order [6] = '{1, 3, 7, 1, 3, 7};

    initial begin
        int         starts;
        int         last_k;
        logic [7:0] prev_rd;
        logic [7:0] rd;
        int         onehot_err, sel_err, frame_err, cells, pkts;
        int         fair_cnt [QUE_NUM];

        rst_n             = 1'b0;
        cfg_limit_rate_en = 1'b0;
        bus.que_nempty    = '0;
        bus.out_rdy       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_que_rd",  {24'd0, bus.que_rd}, 32'd0);
        chk("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_que_sel", {29'd0, bus.que_sel}, 32'd0);
        chk("rst_dbg",     dbg_sig, 32'h01C00000);
        @(negedge clk);
        rst_n = 1'b1;

        // Single queue, back-to-back packets, limit off
        for (int c = 0; c < 8; c++) begin
            step(8'h01, 1'b1);
            chk($sformatf("t1_rd_c%0d", c),   {24'd0, bus.que_rd}, t1_busy[c] ? 32'h01 : 32'h00);
            chk($sformatf("t1_vld_c%0d", c),  {31'd0, bus.out_vld}, {31'd0, t1_vld[c]});
            chk($sformatf("t1_sop_c%0d", c),  {31'd0, bus.out_sop}, {31'd0, t1_sop[c]});
            chk($sformatf("t1_eop_c%0d", c),  {31'd0, bus.out_eop}, {31'd0, t1_eop[c]});
            chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, t1_busy[c]});
        end
        drain();

        // Round robin across queues 1,3,7 with wrap
        for (int k = 0; k < 30; k++) begin
            step(8'h8A, 1'b1);
            if (k == 0 || ((k - 1) % 5) == 4)
                chk($sformatf("t2_rd_k%0d", k), {24'd0, bus.que_rd}, 32'd0);
            else
                chk($sformatf("t2_rd_k%0d", k), {24'd0, bus.que_rd},
                    32'd1 << t2_order[(k - 1) / 5]);
        end
        drain();

        // Stall mid-packet while every queue requests
        for (int s = 0; s < 9; s++) begin
            step(t3_ne[s], t3_rdy[s]);
            chk($sformatf("t3_rd_s%0d", s),  {24'd0, bus.que_rd}, t3_rdm[s] ? 32'h04 : 32'h00);
            chk($sformatf("t3_vld_s%0d", s), {31'd0, bus.out_vld}, {31'd0, t3_vld[s]});
            chk($sformatf("t3_sop_s%0d", s), {31'd0, bus.out_sop}, {31'd0, t3_sop[s]});
            chk($sformatf("t3_eop_s%0d", s), {31'd0, bus.out_eop}, {31'd0, t3_eop[s]});
            if (s > 0) chk($sformatf("t3_sel_s%0d", s), {29'd0, bus.que_sel}, 32'd2);
        end
        drain();

        // Rate limit on: starts every CELL_GAP cycles
        cfg_limit_rate_en = 1'b1;
        prev_rd = '0; starts = 0; last_k = 0;
        for (int k = 0; k < 60; k++) begin
            step(8'h01, 1'b1);
            rd = bus.que_rd;
            if (rd != 0 && prev_rd == 0) begin
                if (starts > 0) chk("t4_on_interval", 32'(k - last_k), 32'd6);
                last_k = k;
                starts++;
            end
            prev_rd = rd;
        end
        chk("t4_on_starts", 32'(starts), 32'd10);
        drain();

        // Rate limit off: 100 packets, starts every PDSZ+1 cycles
        cfg_limit_rate_en = 1'b0;
        prev_rd = '0; starts = 0; last_k = 0;
        for (int k = 0; k < 1000 && starts < 100; k++) begin
            step(8'h01, 1'b1);
            rd = bus.que_rd;
            if (rd != 0 && prev_rd == 0) begin
                if (starts > 0) chk("t4_off_interval", 32'(k - last_k), 32'd5);
                last_k = k;
                starts++;
            end
            prev_rd = rd;
        end
        chk("t4_off_starts", 32'(starts), 32'd100);
        drain();
        chk("t4_pkt_cnt", {16'd0, dbg_sig[15:0]}, 32'd119);

        // Reset in the middle of a packet
        step(8'h08, 1'b1);
        step(8'h08, 1'b1);
        chk("t5_rd1", {24'd0, bus.que_rd}, 32'h08);
        step(8'h08, 1'b1);
        chk("t5_rd2", {24'd0, bus.que_rd}, 32'h08);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rd",   {24'd0, bus.que_rd}, 32'd0);
        chk("t5_rst_vld",  {31'd0, bus.out_vld}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.que_nempty = 8'h04;
        #1;
        chk("t5_rel_dbg", dbg_sig, 32'h01C00000);
        step(8'h00, 1'b1);
        chk("t5_new_rd",  {24'd0, bus.que_rd}, 32'h04);
        chk("t5_new_sel", {29'd0, bus.que_sel}, 32'd2);
        chk("t5_new_dbg", dbg_sig, 32'h02800000);
        step(8'h00, 1'b1);
        chk("t5_new_sop", {30'd0, bus.out_vld, bus.out_sop}, 32'd3);
        drain();
        chk("t5_pkt_cnt", {16'd0, dbg_sig[15:0]}, 32'd1);

        // Random requests and backpressure, then a settle tail with ready held
        onehot_err = 0; sel_err = 0; frame_err = 0; cells = 0; pkts = 0;
        for (int k = 0; k < 3040; k++) begin
            if (k < 3000) step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
            else          step(8'h00, 1'b1);
            rd = bus.que_rd;
            if (rd != 0 && (rd & (rd - 8'd1)) != 0) onehot_err++;
            if (rd != 0 && rd != (8'd1 << bus.que_sel)) sel_err++;
            if (bus.out_vld) begin
                if (bus.out_sop) begin
                    if (cells != 0) frame_err++;
                    cells = 1;
                end else begin
                    if (cells == 0) frame_err++;
                    cells++;
                end
                if (bus.out_eop) begin
                    if (cells != PDSZ) frame_err++;
                    cells = 0;
                    pkts++;
                end
            end else if (bus.out_sop || bus.out_eop) begin
                frame_err++;
            end
        end
        chk("t6_onehot",   32'(onehot_err), 32'd0);
        chk("t6_sel",      32'(sel_err), 32'd0);
        chk("t6_framing",  32'(frame_err), 32'd0);
        chk("t6_open_pkt", 32'(cells), 32'd0);
        chk("t6_activity", {31'd0, pkts > 100}, 32'd1);
        chk("t6_idle",     {31'd0, busy}, 32'd0);

        // Fairness under constant full request: 40 packets over 8 queues
        for (int q = 0; q < QUE_NUM; q++) fair_cnt[q] = 0;
        prev_rd = '0;
        for (int k = 0; k < 200; k++) begin
            step(8'hFF, 1'b1);
            rd = bus.que_rd;
            if (rd != 0 && prev_rd == 0) fair_cnt[bus.que_sel]++;
            prev_rd = rd;
        end
        drain();
        for (int q = 0; q < QUE_NUM; q++)
            chk($sformatf("t6_fair_q%0d", q), 32'(fair_cnt[q]), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
